// File: rtl/cnt_ctrl_sequencer.sv
// Command sequencer driving one up/down counter: LOAD, COUNT_UP/DOWN n, RUN_TO_LIMIT.
// Optional abort/aborted ports are enabled by defining CNT_CTRL_ABORT_EN.
module cnt_ctrl_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             load_n,
    output logic             ce,
    output logic             up_down,
    output logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] steps
`ifdef CNT_CTRL_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int unsigned OP_W = 2;
    localparam logic [OP_W-1:0] OP_LOAD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_UP   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_DOWN = OP_W'(2);
    localparam logic [OP_W-1:0] OP_RUN  = OP_W'(3);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COUNT = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               load_n_q, load_n_d;
    logic               up_down_q, up_down_d;
    logic [WIDTH-1:0]   data_load_q, data_load_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   steps_q, steps_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    logic               accept;
    logic               limit;
    logic               ce_c;
    logic               abort_act;
    logic               unused_count_ok;

    // count_out is observed only through the max_count/zero flags
    assign unused_count_ok = ^count_out;

    assign accept = cmd_valid && ready_q;
    assign limit  = up_down_q ? max_count : zero;

`ifdef CNT_CTRL_ABORT_EN
    logic aborted_q;

    assign abort_act = abort && busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_act;
        end
    end

    assign aborted = aborted_q;
`else
    assign abort_act = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            load_n_q    <= 1'b1;
            up_down_q   <= 1'b1;
            data_load_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            steps_q     <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            load_n_q    <= load_n_d;
            up_down_q   <= up_down_d;
            data_load_q <= data_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            steps_q     <= steps_d;
            rem_q       <= rem_d;
        end
    end

    // Next-state, step bookkeeping and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        up_down_d   = up_down_q;
        data_load_d = data_load_q;
        steps_d     = steps_q;
        rem_d       = rem_q;
        ce_c        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    steps_d = '0;
                    rem_d   = cmd_arg;
                    unique case (cmd_op)
                        OP_LOAD: begin
                            data_load_d = cmd_arg;
                            state_d     = S_LOAD;
                        end
                        OP_UP, OP_DOWN: begin
                            up_down_d = (cmd_op == OP_UP);
                            state_d   = (cmd_arg == '0) ? S_DONE : S_COUNT;
                        end
                        OP_RUN: begin
                            up_down_d = cmd_arg[0];
                            state_d   = S_RUN;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                state_d = S_DONE;
            end
            S_COUNT: begin
                ce_c  = 1'b1;
                rem_d = rem_q - WIDTH'(1);
                if (rem_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                ce_c = !limit;
                if (limit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_act) begin
            ce_c    = 1'b0;
            state_d = S_DONE;
        end

        // steps saturates rather than wrapping
        if (ce_c && (steps_q != '1)) begin
            steps_d = steps_q + WIDTH'(1);
        end

        ready_d  = (state_d == S_IDLE);
        load_n_d = (state_d != S_LOAD);
        busy_d   = (state_d == S_LOAD) || (state_d == S_COUNT) || (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
    end

    // ce follows the limit flag within the cycle; reset and abort force the counter idle
    assign ce        = ce_c && rst_n;
    assign load_n    = load_n_q || abort_act || !rst_n;
    assign cmd_ready = ready_q;
    assign up_down   = up_down_q;
    assign data_load = data_load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign steps     = steps_q;

endmodule

// File: tb/tb_cnt_ctrl_sequencer.sv
// Self-checking bench for cnt_ctrl_sequencer with a behavioural up/down counter attached.
module tb_cnt_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_arg = 4'd0;
    logic       load_n, ce, up_down;
    logic [3:0] data_load;
    logic [3:0] cnt = 4'd0;
    logic       max_c, zero_c;
    logic       busy, done;
    logic [3:0] steps;
`ifdef CNT_CTRL_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    int vecs = 0;
    int errs = 0;
    int ce_cnt = 0, ce_up_cnt = 0, done_cnt = 0, load_cnt = 0, acc_cnt = 0, overlap_cnt = 0;
    logic [3:0] last_load = 4'd0;
    logic [3:0] exp_cnt = 4'd0;

    always #5 clk = ~clk;

    cnt_ctrl_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .load_n(load_n), .ce(ce), .up_down(up_down), .data_load(data_load),
        .count_out(cnt), .max_count(max_c), .zero(zero_c),
        .busy(busy), .done(done), .steps(steps)
`ifdef CNT_CTRL_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    // Counter the sequencer drives
    assign max_c  = (cnt == 4'hF);
    assign zero_c = (cnt == 4'h0);
    always @(posedge clk) begin
        if (load_n === 1'b0) cnt <= data_load;
        else if (ce === 1'b1) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    end

    // Mid-cycle event counters
    always @(negedge clk) begin
        if (ce === 1'b1) begin
            ce_cnt = ce_cnt + 1;
            if (up_down === 1'b1) ce_up_cnt = ce_up_cnt + 1;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (load_n === 1'b0) begin
            load_cnt  = load_cnt + 1;
            last_load = data_load;
        end
        if (cmd_valid && cmd_ready === 1'b1) acc_cnt = acc_cnt + 1;
        if (cmd_ready === 1'b1 && busy === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command and check it against arithmetic expectations
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] arg);
        int j, lat, e_steps, e_up, e_load, e_lat;
        int b_ce, b_up, b_done, b_load;
        logic [3:0] e_cnt;
        e_load = 0;
        e_up   = 0;
        case (op)
            2'd0: begin e_steps = 0; e_cnt = arg; e_lat = 2; e_load = 1; end
            2'd1: begin e_steps = arg; e_cnt = exp_cnt + arg; e_lat = arg + 1; e_up = arg; end
            2'd2: begin e_steps = arg; e_cnt = exp_cnt - arg; e_lat = arg + 1; end
            default: begin
                if (arg[0]) begin
                    e_steps = 15 - int'(exp_cnt); e_cnt = 4'hF; e_up = e_steps;
                end else begin
                    e_steps = int'(exp_cnt); e_cnt = 4'h0;
                end
                e_lat = e_steps + 2;
            end
        endcase
        cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
        j = 0;
        while (cmd_ready !== 1'b1 && j < 50) begin tick(); j++; end
        vecs++;
        if (cmd_ready !== 1'b1) begin
            errs++; $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        b_ce = ce_cnt; b_up = ce_up_cnt; b_done = done_cnt; b_load = load_cnt;
        tick();
        cmd_valid = 1'b0;
        j = 0;
        while (done !== 1'b1 && j < 100) begin tick(); j++; end
        lat = j + 1;
        vecs++;
        if (lat !== e_lat) begin
            errs++; $display("FAIL latency op=%0d arg=%0d: got %0d required %0d", op, arg, lat, e_lat);
        end
        tick();
        vecs++;
        if (steps !== 4'(e_steps)) begin
            errs++; $display("FAIL steps op=%0d arg=%0d: got %0d required %0d", op, arg, steps, e_steps);
        end
        vecs++;
        if (cnt !== e_cnt) begin
            errs++; $display("FAIL count_out op=%0d arg=%0d: got %h required %h", op, arg, cnt, e_cnt);
        end
        vecs++;
        if (ce_cnt - b_ce !== e_steps) begin
            errs++; $display("FAIL ce_cycles op=%0d arg=%0d: got %0d required %0d", op, arg, ce_cnt - b_ce, e_steps);
        end
        vecs++;
        if (ce_up_cnt - b_up !== e_up) begin
            errs++; $display("FAIL ce_up_cycles op=%0d arg=%0d: got %0d required %0d", op, arg, ce_up_cnt - b_up, e_up);
        end
        vecs++;
        if (done_cnt - b_done !== 1) begin
            errs++; $display("FAIL done_pulses op=%0d: got %0d required 1", op, done_cnt - b_done);
        end
        vecs++;
        if (load_cnt - b_load !== e_load) begin
            errs++; $display("FAIL load_cycles op=%0d: got %0d required %0d", op, load_cnt - b_load, e_load);
        end
        if (op == 2'd0) begin
            vecs++;
            if (last_load !== arg) begin
                errs++; $display("FAIL data_load: got %h required %h", last_load, arg);
            end
        end
        vecs++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errs++; $display("FAIL idle_after op=%0d: busy=%b ready=%b required 0/1", op, busy, cmd_ready);
        end
        exp_cnt = e_cnt;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 4'd3;
        tick(); tick();
        vecs++;
        if ({cmd_ready, load_n, ce, busy, done, up_down} !== 6'b010001 || steps !== 4'd0 || data_load !== 4'd0) begin
            errs++;
            $display("FAIL reset_outputs: ready=%b load_n=%b ce=%b busy=%b done=%b up_down=%b steps=%0d data_load=%h required 0 1 0 0 0 1 0 0",
                     cmd_ready, load_n, ce, busy, done, up_down, steps, data_load);
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        vecs++;
        if (cmd_ready !== 1'b1) begin
            errs++; $display("FAIL ready_after_release: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_load;
        do_cmd(2'd0, 4'h5);
    endtask

    task automatic test_count_wrap;
        do_cmd(2'd0, 4'hE);
        do_cmd(2'd1, 4'd3);
    endtask

    task automatic test_count_zero;
        do_cmd(2'd0, 4'h4);
        do_cmd(2'd2, 4'd0);
    endtask

    task automatic test_run;
        do_cmd(2'd0, 4'hC);
        do_cmd(2'd3, 4'd1);
        do_cmd(2'd3, 4'd0);
        do_cmd(2'd3, 4'd0);
        do_cmd(2'd3, 4'hE);
    endtask

    task automatic test_reset_midcmd;
        int j, b_done;
        do_cmd(2'd0, 4'h0);
        cmd_op = 2'd1; cmd_arg = 4'd6; cmd_valid = 1'b1;
        j = 0;
        while (cmd_ready !== 1'b1 && j < 50) begin tick(); j++; end
        tick();
        cmd_valid = 1'b0;
        b_done = done_cnt;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vecs++;
        if ({busy, ce, done, cmd_ready} !== 4'b0000 || steps !== 4'd0) begin
            errs++;
            $display("FAIL midcmd_reset: busy=%b ce=%b done=%b ready=%b steps=%0d required all 0",
                     busy, ce, done, cmd_ready, steps);
        end
        tick(); tick(); tick();
        vecs++;
        if (done_cnt - b_done !== 0 || cmd_ready !== 1'b1) begin
            errs++;
            $display("FAIL midcmd_no_done: done_pulses=%0d ready=%b required 0/1", done_cnt - b_done, cmd_ready);
        end
        do_cmd(2'd0, 4'h9);
    endtask

    task automatic test_back_to_back;
        logic [1:0] ops [4];
        logic [3:0] args[4];
        int j, b_acc, b_done, b_ovl;
        ops[0] = 2'd0; args[0] = 4'h3;
        ops[1] = 2'd1; args[1] = 4'd2;
        ops[2] = 2'd2; args[2] = 4'd1;
        ops[3] = 2'd3; args[3] = 4'd1;
        b_acc = acc_cnt; b_done = done_cnt; b_ovl = overlap_cnt;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_op = ops[i]; cmd_arg = args[i];
            j = 0;
            while (cmd_ready !== 1'b1 && j < 100) begin tick(); j++; end
            tick();
        end
        cmd_valid = 1'b0;
        j = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && j < 100) begin tick(); j++; end
        tick();
        exp_cnt = 4'hF;
        vecs++;
        if (acc_cnt - b_acc !== 4) begin
            errs++; $display("FAIL b2b_accepts: got %0d required 4", acc_cnt - b_acc);
        end
        vecs++;
        if (done_cnt - b_done !== 4) begin
            errs++; $display("FAIL b2b_done_pulses: got %0d required 4", done_cnt - b_done);
        end
        vecs++;
        if (overlap_cnt - b_ovl !== 0) begin
            errs++; $display("FAIL b2b_ready_while_busy: got %0d required 0", overlap_cnt - b_ovl);
        end
        vecs++;
        if (cnt !== 4'hF || steps !== 4'd11) begin
            errs++; $display("FAIL b2b_result: count=%h steps=%0d required f 11", cnt, steps);
        end
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [3:0] arg;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            arg = 4'($urandom_range(0, 15));
            do_cmd(op, arg);
        end
    endtask

`ifdef CNT_CTRL_ABORT_EN
    task automatic test_abort;
        do_cmd(2'd0, 4'h0);
        cmd_op = 2'd1; cmd_arg = 4'd10; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        abort = 1'b1;
        #1;
        vecs++;
        if (ce !== 1'b0) begin
            errs++; $display("FAIL abort_ce: got %b required 0", ce);
        end
        tick();
        abort = 1'b0;
        vecs++;
        if (done !== 1'b1 || aborted !== 1'b1 || steps !== 4'd2) begin
            errs++; $display("FAIL abort_done: done=%b aborted=%b steps=%0d required 1 1 2", done, aborted, steps);
        end
        tick();
        exp_cnt = 4'd2;
        vecs++;
        if (cnt !== 4'd2 || busy !== 1'b0) begin
            errs++; $display("FAIL abort_result: count=%h busy=%b required 2 0", cnt, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_count_wrap();
        test_count_zero();
        test_run();
        test_reset_midcmd();
        test_back_to_back();
`ifdef CNT_CTRL_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
